// File: rtl/enemy_controller.sv
// Per-enemy AI sequencer: idles, chases the player horizontally, attacks in range,
// then cools down. Everything advances only on enabled frame ticks.
module enemy_controller #(
  parameter logic [7:0] X_INIT          = 8'd120,
  parameter logic [7:0] Y_INIT          = 8'd160,
  parameter logic [7:0] X_MIN           = 8'd8,
  parameter logic [7:0] X_MAX           = 8'd232,
  parameter logic [7:0] ATTACK_RANGE    = 8'd12,
  parameter int         STEP_FRAMES     = 4,
  parameter int         IDLE_FRAMES     = 16,
  parameter int         COOLDOWN_FRAMES = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic [7:0] player_x,
  output logic [7:0] enemy_x,
  output logic [7:0] enemy_y,
  output logic [1:0] behavior,
  output logic       is_left,
  output logic [1:0] period,
  output logic       attack_hit
);

  localparam int AW = $clog2(STEP_FRAMES + 1);
  localparam int WMAX = (IDLE_FRAMES > COOLDOWN_FRAMES) ? IDLE_FRAMES : COOLDOWN_FRAMES;
  localparam int WW = $clog2(WMAX + 1);
  localparam logic [AW-1:0] ANIM_LAST = AW'(STEP_FRAMES - 1);
  localparam logic [WW-1:0] IDLE_LAST = WW'(IDLE_FRAMES - 1);
  localparam logic [WW-1:0] COOL_LAST = WW'(COOLDOWN_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, WALK, ATTACK, COOLDOWN} state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_x, w_x_nxt;
  logic [1:0]    r_beh, w_beh_nxt;
  logic          r_left, w_left_nxt;
  logic [1:0]    r_period, w_period_nxt;
  logic [AW-1:0] r_anim, w_anim_nxt;
  logic [WW-1:0] r_wait, w_wait_nxt;
  logic          r_hit, w_hit_nxt;

  logic          w_tick;
  logic [8:0]    w_dist;
  logic          w_near;
  logic          w_anim_wrap;

  assign w_tick      = frame_tick & enable;
  assign w_dist      = (player_x >= r_x) ? ({1'b0, player_x} - {1'b0, r_x})
                                         : ({1'b0, r_x} - {1'b0, player_x});
  assign w_near      = (w_dist <= {1'b0, ATTACK_RANGE});
  assign w_anim_wrap = (r_anim == ANIM_LAST);

  always_comb begin
    w_state_nxt  = r_state;
    w_x_nxt      = r_x;
    w_left_nxt   = r_left;
    w_period_nxt = r_period;
    w_anim_nxt   = r_anim;
    w_wait_nxt   = r_wait;
    w_hit_nxt    = 1'b0;
    if (w_tick) begin
      case (r_state)
        IDLE: begin
          if (r_wait == IDLE_LAST) begin
            w_wait_nxt   = '0;
            w_state_nxt  = w_near ? ATTACK : WALK;
            w_anim_nxt   = '0;
            w_period_nxt = 2'd0;
          end else begin
            w_wait_nxt = r_wait + 1'b1;
          end
        end
        WALK: begin
          if (w_near) begin
            w_state_nxt  = ATTACK;
            w_anim_nxt   = '0;
            w_period_nxt = 2'd0;
          end else begin
            w_left_nxt = (player_x < r_x);
            // At a bound the enemy holds position but keeps walking in place.
            if (player_x > r_x && r_x < X_MAX) w_x_nxt = r_x + 8'd1;
            else if (player_x < r_x && r_x > X_MIN) w_x_nxt = r_x - 8'd1;
            if (w_anim_wrap) begin
              w_anim_nxt   = '0;
              w_period_nxt = r_period + 2'd1;
            end else begin
              w_anim_nxt = r_anim + 1'b1;
            end
          end
        end
        ATTACK: begin
          if (w_anim_wrap) begin
            w_anim_nxt = '0;
            if (r_period == 2'd3) begin
              w_state_nxt  = COOLDOWN;
              w_period_nxt = 2'd0;
            end else begin
              w_period_nxt = r_period + 2'd1;
              w_hit_nxt    = (r_period == 2'd1);
            end
          end else begin
            w_anim_nxt = r_anim + 1'b1;
          end
        end
        COOLDOWN: begin
          if (r_wait == COOL_LAST) begin
            w_wait_nxt   = '0;
            w_state_nxt  = WALK;
            w_anim_nxt   = '0;
            w_period_nxt = 2'd0;
          end else begin
            w_wait_nxt = r_wait + 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_beh_nxt = 2'd0;
    case (w_state_nxt)
      WALK:    w_beh_nxt = 2'd1;
      ATTACK:  w_beh_nxt = 2'd2;
      default: w_beh_nxt = 2'd0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_x      <= X_INIT;
      r_beh    <= 2'd0;
      r_left   <= 1'b0;
      r_period <= 2'd0;
      r_anim   <= '0;
      r_wait   <= '0;
      r_hit    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_x      <= w_x_nxt;
      r_beh    <= w_beh_nxt;
      r_left   <= w_left_nxt;
      r_period <= w_period_nxt;
      r_anim   <= w_anim_nxt;
      r_wait   <= w_wait_nxt;
      r_hit    <= w_hit_nxt;
    end
  end

  assign enemy_x    = r_x;
  assign enemy_y    = Y_INIT;
  assign behavior   = r_beh;
  assign is_left    = r_left;
  assign period     = r_period;
  assign attack_hit = r_hit;

endmodule

// File: tb/tb_enemy_controller.sv
// Directed bench for enemy_controller: hand-computed expectations at default parameters.
module tb_enemy_controller;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_tick;
  logic       enable;
  logic [7:0] player_x;
  logic [7:0] enemy_x;
  logic [7:0] enemy_y;
  logic [1:0] behavior;
  logic       is_left;
  logic [1:0] period;
  logic       attack_hit;

  int errors = 0;
  int checks = 0;
  int hits;
  int hit_at;

  enemy_controller dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .enable     (enable),
    .player_x   (player_x),
    .enemy_x    (enemy_x),
    .enemy_y    (enemy_y),
    .behavior   (behavior),
    .is_left    (is_left),
    .period     (period),
    .attack_hit (attack_hit)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      @(posedge Clk);
      #1;
      frame_tick = 1'b0;
    end
  endtask

  task automatic do_reset(input logic [7:0] px);
    player_x = px;
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_x"}, 32'(enemy_x), 32'd120);
    chk({tag, "_y"}, 32'(enemy_y), 32'd160);
    chk({tag, "_beh"}, 32'(behavior), 32'd0);
    chk({tag, "_left"}, 32'(is_left), 32'd0);
    chk({tag, "_period"}, 32'(period), 32'd0);
    chk({tag, "_hit"}, 32'(attack_hit), 32'd0);
  endtask

  initial begin
    Reset = 1'b1; frame_tick = 1'b0; enable = 1'b1; player_x = 8'd200;
    @(posedge Clk); #1;
    do_reset(8'd200);
    chk_reset_vals("rst");

    // Chase right: 16 idle ticks, then 10 walk ticks.
    tick(15);
    chk("idle_beh", 32'(behavior), 32'd0);
    tick(1);
    chk("walk_beh", 32'(behavior), 32'd1);
    tick(10);
    chk("right_x", 32'(enemy_x), 32'd130);
    chk("right_left", 32'(is_left), 32'd0);
    chk("right_period", 32'(period), 32'd2);

    // Ticks ignored while disabled; resume from anim_cnt=2, period=2.
    enable = 1'b0;
    tick(20);
    chk("gate_x", 32'(enemy_x), 32'd130);
    chk("gate_period", 32'(period), 32'd2);
    chk("gate_beh", 32'(behavior), 32'd1);
    chk("gate_left", 32'(is_left), 32'd0);
    enable = 1'b1;
    tick(1);
    chk("resume1_x", 32'(enemy_x), 32'd131);
    chk("resume1_period", 32'(period), 32'd2);
    tick(1);
    chk("resume2_x", 32'(enemy_x), 32'd132);
    chk("resume2_period", 32'(period), 32'd3);

    // Reset mid-WALK, then reset coincident with a tick.
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    chk_reset_vals("rst_walk");
    tick(19);
    chk("rewalk_x", 32'(enemy_x), 32'd123);
    Reset = 1'b1; frame_tick = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0; frame_tick = 1'b0;
    chk_reset_vals("rst_tick");

    // Chase left into attack, cooldown, back to walk.
    player_x = 8'd60;
    tick(16);
    chk("left_beh", 32'(behavior), 32'd1);
    tick(48);
    chk("left_x", 32'(enemy_x), 32'd72);
    chk("left_left", 32'(is_left), 32'd1);
    chk("left_beh2", 32'(behavior), 32'd1);
    tick(1);
    chk("atk_beh", 32'(behavior), 32'd2);
    chk("atk_period", 32'(period), 32'd0);
    chk("atk_x", 32'(enemy_x), 32'd72);
    hits = 0; hit_at = -1;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (attack_hit === 1'b1) begin hits++; hit_at = i; end
      if (i == 14) chk("atk_last_beh", 32'(behavior), 32'd2);
    end
    chk("hit_count", 32'(hits), 32'd1);
    chk("hit_tick", 32'(hit_at), 32'd7);
    chk("cool_beh", 32'(behavior), 32'd0);
    chk("cool_period", 32'(period), 32'd0);
    chk("cool_x", 32'(enemy_x), 32'd72);
    chk("cool_left", 32'(is_left), 32'd1);
    chk("cool_hit", 32'(attack_hit), 32'd0);
    tick(7);
    chk("cool_end_beh", 32'(behavior), 32'd0);
    tick(1);
    chk("rewalk_beh", 32'(behavior), 32'd1);

    // Clamp at X_MAX while animation keeps cycling.
    do_reset(8'd255);
    tick(16 + 112);
    chk("clamp_x", 32'(enemy_x), 32'd232);
    chk("clamp_beh", 32'(behavior), 32'd1);
    chk("clamp_period", 32'(period), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      tick(4);
      chk("clamp_hold_x", 32'(enemy_x), 32'd232);
      chk("clamp_hold_beh", 32'(behavior), 32'd1);
      chk("clamp_cycle", 32'(period), 32'(k % 4));
    end

    // Player in range at IDLE exit goes straight to ATTACK.
    do_reset(8'd125);
    tick(15);
    chk("imm_idle_beh", 32'(behavior), 32'd0);
    tick(1);
    chk("imm_beh", 32'(behavior), 32'd2);
    chk("imm_period", 32'(period), 32'd0);
    chk("imm_x", 32'(enemy_x), 32'd120);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/enemy_controller.md
# enemy_controller

Per-enemy behaviour sequencer that drives the enemy sprite-selection logic. It produces the enemy position, behaviour code (0 stand, 1 walk, 2 attack), facing, and 2-bit animation period. It steps a small AI state machine and animation counter once per video frame, chasing the player horizontally and attacking when in range. One instance per on-screen enemy sits between the game-state logic and the sprite/draw path.

## Interface
Parameters:
- X_INIT, 8'd120, x position after reset
- Y_INIT, 8'd160, y position (ground line, constant)
- X_MIN, 8'd8, leftmost legal x
- X_MAX, 8'd232, rightmost legal x
- ATTACK_RANGE, 8'd12, attack triggers when |player_x − enemy_x| ≤ this
- STEP_FRAMES, 4, frame ticks per animation period step (≥1)
- IDLE_FRAMES, 16, frame ticks spent in IDLE (≥1)
- COOLDOWN_FRAMES, 8, frame ticks spent in COOLDOWN (≥1)

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-Clk pulse per video frame
- enable  in  1  when low, ticks are ignored and all state holds
- player_x  in  8  player x position
- enemy_x  out  8  enemy x position
- enemy_y  out  8  enemy y position (always Y_INIT)
- behavior  out  2  0 stand, 1 walk, 2 attack (3 never driven)
- is_left  out  1  1 = facing left
- period  out  2  animation frame index
- attack_hit  out  1  one-Clk pulse at the active attack frame

## Operation
- The clock is Clk. Reset is synchronous and active-high. All outputs are registered.
- Reset values: enemy_x=X_INIT, enemy_y=Y_INIT, behavior=0, is_left=0, period=0, attack_hit=0, state=IDLE, all counters 0.
- An update happens only on a Clk edge with frame_tick=1 and enable=1 (a "tick"). Otherwise everything holds and attack_hit=0.
- dist = |player_x − enemy_x|, computed 9-bit and unsigned, from the pre-update enemy_x.
- Animation counter anim_cnt runs 0..STEP_FRAMES−1. On the tick where it equals STEP_FRAMES−1: anim_cnt←0 and period←period+1 (mod 4, so 3 wraps to 0). This applies only in WALK and ATTACK.
- States:
  - IDLE (behavior 0, period 0):
    - Each tick, wait_cnt++.
    - On the tick with wait_cnt=IDLE_FRAMES−1: wait_cnt←0.
    - Then, if dist≤ATTACK_RANGE, go to ATTACK; otherwise go to WALK.
  - WALK (behavior 1):
    - On each tick, if dist≤ATTACK_RANGE, go to ATTACK. No move happens on that tick.
    - Otherwise set is_left←(player_x<enemy_x), move enemy_x by 1 toward player_x, and advance the animation.
    - Movement is clamped to [X_MIN, X_MAX]. At a bound the enemy holds position but stays in WALK and keeps animating.
  - ATTACK (behavior 2):
    - is_left is frozen and enemy_x does not change.
    - The animation advances normally.
    - attack_hit←1 for exactly one Clk, on the tick where period goes 1→2.
    - On the tick where period would wrap 3→0, go to COOLDOWN.
  - COOLDOWN (behavior 0, period 0):
    - Each tick, wait_cnt++.
    - On wait_cnt=COOLDOWN_FRAMES−1: wait_cnt←0 and go to WALK.
- Every state entry clears anim_cnt and period to 0.

## Timing
- Outputs change on the same Clk edge that samples the tick. There is no additional latency.
- attack_hit is high for one Clk cycle following that edge, then returns to 0.
- ATTACK lasts exactly 4×STEP_FRAMES ticks (16 at defaults). attack_hit fires after 2×STEP_FRAMES−1 ticks in ATTACK, counting from the entry tick as tick 0.
- IDLE lasts IDLE_FRAMES ticks. COOLDOWN lasts COOLDOWN_FRAMES ticks.
- Reset takes priority over a simultaneous frame_tick. Reset during any state returns all outputs to their reset values on that edge.
- enable=0 with frame_tick=1 behaves as a non-tick. Counters do not advance.
- player_x may change at any time. It is sampled only on ticks.

## Test plan
- Reset: assert Reset for 1 Clk during WALK → enemy_x=120, enemy_y=160, behavior=0, is_left=0, period=0, attack_hit=0 on that edge. Reset and frame_tick high together → reset values.
- Chase right: player_x=200, 16 ticks → behavior=1. After 10 more ticks → enemy_x=130, is_left=0, period=2.
- Chase left then attack: player_x=60 → is_left=1, and enemy_x reaches 72 after 48 WALK ticks. Next tick → behavior=2, period=0, enemy_x=72. attack_hit pulses once, at ATTACK tick 7. After 16 ATTACK ticks → behavior=0 (COOLDOWN). 8 ticks later → behavior=1.
- Clamp: player_x=255 → enemy_x stops at 232 and behavior stays 1. Period keeps cycling 0,1,2,3,0.
- Enable gating: enable=0 for 20 frame_ticks mid-WALK → all outputs unchanged. Re-enable → resumes from the same anim_cnt and period.
- Immediate attack: player_x=125 at reset → after 16 ticks, behavior goes 0→2 directly with period=0.
